// File: rtl/cp0_exc_unit.sv
// Coprocessor-0 exception unit: SR/Cause/EPC/PRId, interrupt/exception arbitration and eret.
// Optional macro CP0_FWD_EN forwards a same-cycle mtc0 write onto DOut/epcValue.
module cp0_exc_unit #(
    parameter logic [31:0] PRID      = 32'h4D49_5053,
    parameter int unsigned NUM_HWINT = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 WE,
    input  logic [4:0]           A1,
    input  logic [4:0]           A2,
    input  logic [31:0]          DIn,
    input  logic [31:0]          pcValue_MEM,
    input  logic                 BD_MEM,
    input  logic [4:0]           ExcCode_MEM,
    input  logic [NUM_HWINT-1:0] HWInt,
    input  logic                 eret_MEM,
    output logic [31:0]          DOut,
    output logic                 flush,
    output logic                 epc_WE,
    output logic [31:0]          epcValue
);

    localparam logic [4:0] RegSr    = 5'd12;
    localparam logic [4:0] RegCause = 5'd13;
    localparam logic [4:0] RegEpc   = 5'd14;
    localparam logic [4:0] RegPrid  = 5'd15;

    logic [NUM_HWINT-1:0] sr_im_q, sr_im_d;
    logic                 sr_exl_q, sr_exl_d;
    logic                 sr_ie_q, sr_ie_d;
    logic                 cause_bd_q, cause_bd_d;
    logic [NUM_HWINT-1:0] cause_ip_q;
    logic [4:0]           cause_exc_q, cause_exc_d;
    logic [31:2]          epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic        mtc0_ok;
    logic [31:0] epc_next;
    logic [31:0] sr_rd;
    logic [31:0] cause_rd;

    assign int_req  = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req  = (ExcCode_MEM != 5'd0) & ~sr_exl_q;
    assign flush    = int_req | exc_req;
    assign epc_WE   = eret_MEM & ~flush;
    assign mtc0_ok  = WE & ~flush;
    // A faulting delay-slot instruction restarts at its branch.
    assign epc_next = BD_MEM ? (pcValue_MEM - 32'd4) : pcValue_MEM;

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (flush) begin
            sr_exl_d    = 1'b1;
            cause_exc_d = int_req ? 5'd0 : ExcCode_MEM;
            cause_bd_d  = BD_MEM;
            epc_d       = epc_next[31:2];
        end else begin
            if (WE && A2 == RegSr) begin
                sr_im_d  = DIn[10 +: NUM_HWINT];
                sr_exl_d = DIn[1];
                sr_ie_d  = DIn[0];
            end
            if (WE && A2 == RegEpc) begin
                epc_d = DIn[31:2];
            end
            // eret's EXL clear overrides a coincident mtc0 to SR.
            if (epc_WE) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= 5'd0;
            epc_q       <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= HWInt;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

    always_comb begin
        sr_rd                   = '0;
        sr_rd[10 +: NUM_HWINT]  = sr_im_q;
        sr_rd[1]                = sr_exl_q;
        sr_rd[0]                = sr_ie_q;
        cause_rd                = '0;
        cause_rd[31]            = cause_bd_q;
        cause_rd[10 +: NUM_HWINT] = cause_ip_q;
        cause_rd[6:2]           = cause_exc_q;
    end

`ifdef CP0_FWD_EN
    logic [31:0] sr_wr_val;
    logic [31:0] epc_wr_val;

    always_comb begin
        sr_wr_val                  = '0;
        sr_wr_val[10 +: NUM_HWINT] = DIn[10 +: NUM_HWINT];
        sr_wr_val[1:0]             = DIn[1:0];
    end
    assign epc_wr_val = {DIn[31:2], 2'b00};
`endif

    always_comb begin
        unique case (A1)
            RegSr:    DOut = sr_rd;
            RegCause: DOut = cause_rd;
            RegEpc:   DOut = {epc_q, 2'b00};
            RegPrid:  DOut = PRID;
            default:  DOut = '0;
        endcase
        epcValue = {epc_q, 2'b00};
`ifdef CP0_FWD_EN
        if (mtc0_ok && A1 == A2 && A2 == RegSr) begin
            DOut = sr_wr_val;
        end
        if (mtc0_ok && A1 == A2 && A2 == RegEpc) begin
            DOut = epc_wr_val;
        end
        if (mtc0_ok && A2 == RegEpc) begin
            epcValue = epc_wr_val;
        end
`else
        if (mtc0_ok && 1'b0) begin
            DOut = '0;
        end
`endif
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed, table-driven bench for cp0_exc_unit; honours CP0_FWD_EN when defined.
module tb_cp0_exc_unit;

    localparam logic [31:0] PRID = 32'h4D49_5053;

    logic        clk = 1'b0;
    logic        reset;
    logic        WE;
    logic [4:0]  A1, A2;
    logic [31:0] DIn, pcValue_MEM;
    logic        BD_MEM;
    logic [4:0]  ExcCode_MEM;
    logic [5:0]  HWInt;
    logic        eret_MEM;
    logic [31:0] DOut;
    logic        flush;
    logic        epc_WE;
    logic [31:0] epcValue;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    cp0_exc_unit #(.PRID(PRID), .NUM_HWINT(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .WE          (WE),
        .A1          (A1),
        .A2          (A2),
        .DIn         (DIn),
        .pcValue_MEM (pcValue_MEM),
        .BD_MEM      (BD_MEM),
        .ExcCode_MEM (ExcCode_MEM),
        .HWInt       (HWInt),
        .eret_MEM    (eret_MEM),
        .DOut        (DOut),
        .flush       (flush),
        .epc_WE      (epc_WE),
        .epcValue    (epcValue)
    );

    typedef struct {
        logic        we;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] din;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        eret;
        logic [31:0] exp_dout;
        logic        exp_flush;
        logic        exp_ewe;
        logic [31:0] exp_epcv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [4:0] a1, logic [4:0] a2, logic [31:0] din,
                                logic [31:0] pc, logic bd, logic [4:0] exc, logic [5:0] hw,
                                logic eret, logic [31:0] ed, logic ef, logic ee,
                                logic [31:0] ev);
        vec_t v;
        v.we = we; v.a1 = a1; v.a2 = a2; v.din = din; v.pc = pc; v.bd = bd;
        v.exc = exc; v.hw = hw; v.eret = eret;
        v.exp_dout = ed; v.exp_flush = ef; v.exp_ewe = ee; v.exp_epcv = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle();
        WE = 0; A1 = 0; A2 = 0; DIn = 0; pcValue_MEM = 0; BD_MEM = 0;
        ExcCode_MEM = 0; HWInt = 0; eret_MEM = 0;
    endtask

    initial begin
        logic [31:0] fwd_dout;
        logic [31:0] fwd_epcv;
        string       tag;
`ifdef CP0_FWD_EN
        fwd_dout = 32'h0000_3014;
        fwd_epcv = 32'h0000_3014;
`else
        fwd_dout = 32'h0000_4000;
        fwd_epcv = 32'h0000_4000;
`endif
        //                  we a1  a2  din            pc             bd exc hw         eret dout  flush ewe epcv
        vecs.push_back(mk(0, 15, 0,  0,             0,             0, 0,  6'b000000, 0, PRID,         0, 0, 0));
        vecs.push_back(mk(0, 12, 0,  0,             0,             0, 0,  6'b000000, 0, 0,            0, 0, 0));
        vecs.push_back(mk(0, 13, 0,  0,             0,             0, 0,  6'b000000, 0, 0,            0, 0, 0));
        vecs.push_back(mk(0, 14, 0,  0,             0,             0, 0,  6'b000000, 0, 0,            0, 0, 0));
        vecs.push_back(mk(1, 13, 12, 32'h0000_0401, 0,             0, 0,  6'b000000, 0, 0,            0, 0, 0));
        vecs.push_back(mk(0, 12, 0,  0,             32'h0000_2000, 0, 0,  6'b000001, 0, 32'h0000_0401, 1, 0, 0));
        vecs.push_back(mk(0, 13, 0,  0,             0,             0, 0,  6'b000000, 0, 32'h0000_0400, 0, 0, 32'h0000_2000));
        vecs.push_back(mk(0, 12, 0,  0,             0,             0, 0,  6'b000000, 0, 32'h0000_0403, 0, 0, 32'h0000_2000));
        vecs.push_back(mk(0, 14, 0,  0,             32'h0000_5000, 0, 10, 6'b000000, 0, 32'h0000_2000, 0, 0, 32'h0000_2000));
        vecs.push_back(mk(0, 13, 0,  0,             0,             0, 0,  6'b000000, 1, 0,            0, 1, 32'h0000_2000));
        vecs.push_back(mk(0, 12, 0,  0,             32'h0000_3008, 1, 4,  6'b000000, 0, 32'h0000_0401, 1, 0, 32'h0000_2000));
        vecs.push_back(mk(0, 13, 0,  0,             0,             0, 0,  6'b000000, 0, 32'h8000_0010, 0, 0, 32'h0000_3004));
        vecs.push_back(mk(1, 14, 12, 32'h0000_0C03, 0,             0, 0,  6'b000000, 1, 32'h0000_3004, 0, 1, 32'h0000_3004));
        vecs.push_back(mk(0, 12, 0,  0,             32'h0000_4000, 0, 12, 6'b000000, 1, 32'h0000_0C01, 1, 0, 32'h0000_3004));
        vecs.push_back(mk(0, 13, 0,  0,             0,             0, 0,  6'b000000, 0, 32'h0000_0030, 0, 0, 32'h0000_4000));
        vecs.push_back(mk(0, 12, 0,  0,             0,             0, 0,  6'b000000, 0, 32'h0000_0C03, 0, 0, 32'h0000_4000));
        vecs.push_back(mk(1, 14, 14, 32'h0000_3017, 0,             0, 0,  6'b000000, 0, fwd_dout,     0, 0, fwd_epcv));
        vecs.push_back(mk(1, 14, 12, 32'h0000_0401, 0,             0, 0,  6'b000000, 0, 32'h0000_3014, 0, 0, 32'h0000_3014));
        vecs.push_back(mk(1, 12, 14, 32'h0000_1234, 0,             1, 4,  6'b000001, 0, 32'h0000_0401, 1, 0, 32'h0000_3014));
        vecs.push_back(mk(0, 13, 0,  0,             0,             0, 0,  6'b000000, 0, 32'h8000_0400, 0, 0, 32'hFFFF_FFFC));
        vecs.push_back(mk(1, 14, 12, 32'h0000_0401, 0,             0, 0,  6'b000000, 0, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC));
        vecs.push_back(mk(0, 12, 0,  0,             0,             0, 0,  6'b000010, 0, 32'h0000_0401, 0, 0, 32'hFFFF_FFFC));
        vecs.push_back(mk(0, 13, 0,  0,             0,             0, 0,  6'b000000, 0, 32'h8000_0800, 0, 0, 32'hFFFF_FFFC));

        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        foreach (vecs[i]) begin
            WE = vecs[i].we; A1 = vecs[i].a1; A2 = vecs[i].a2; DIn = vecs[i].din;
            pcValue_MEM = vecs[i].pc; BD_MEM = vecs[i].bd; ExcCode_MEM = vecs[i].exc;
            HWInt = vecs[i].hw; eret_MEM = vecs[i].eret;
            #1;
            tag = $sformatf("v%0d", i);
            chk({tag, ".DOut"}, DOut, vecs[i].exp_dout);
            chk({tag, ".flush"}, {31'd0, flush}, {31'd0, vecs[i].exp_flush});
            chk({tag, ".epc_WE"}, {31'd0, epc_WE}, {31'd0, vecs[i].exp_ewe});
            chk({tag, ".epcValue"}, epcValue, vecs[i].exp_epcv);
            @(posedge clk);
            #1;
        end

        // Reset coincident with an interrupt and an mtc0 must leave reset values.
        idle();
        HWInt = 6'b000001; WE = 1; A2 = 14; DIn = 32'h0000_5000; reset = 1;
        #1 chk("rst_flush_seen", {31'd0, flush}, 32'd1);
        @(posedge clk);
        #1;
        idle();
        reset = 0;
        #1;
        chk("rst.flush", {31'd0, flush}, 32'd0);
        chk("rst.epcValue", epcValue, 32'd0);
        A1 = 12; #1 chk("rst.SR", DOut, 32'd0);
        A1 = 13; #1 chk("rst.Cause", DOut, 32'd0);
        A1 = 14; #1 chk("rst.EPC", DOut, 32'd0);
        A1 = 15; #1 chk("rst.PRId", DOut, PRID);
        A1 = 7;  #1 chk("rst.other", DOut, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
